// File: rtl/dct_da_accumulator_if.sv
// ============================================================================
// Module  : dct_da_accumulator_if
// Brief   : Sample handshake, coefficient ROM port and result bus of the
//           DA shift-accumulate engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dct_da_accumulator_if #(
    parameter int IN_W  = 16,
    parameter int ROM_W = 16,
    parameter int ACC_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic        [IN_W-1:0]   x1;
    logic        [IN_W-1:0]   x2;
    logic        [IN_W-1:0]   x3;
    logic                     rom_cs;
    logic        [2:0]        rom_addr;
    logic signed [ROM_W-1:0]  rom_data;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  dout;

    modport slave (
        input  in_valid, x1, x2, x3, rom_data,
        output in_ready, rom_cs, rom_addr, out_valid, dout
    );

    modport master (
        output in_valid, x1, x2, x3, rom_data,
        input  in_ready, rom_cs, rom_addr, out_valid, dout
    );
endinterface

`default_nettype wire

// File: rtl/dct_da_accumulator.sv
// ============================================================================
// Module  : dct_da_accumulator
// Brief   : Bit-serial distributed-arithmetic shift-accumulate engine; walks
//           three latched samples MSB-first against an external DA ROM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_da_accumulator #(
    parameter int IN_W  = 16,
    parameter int ROM_W = 16,
    parameter int ACC_W = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    dct_da_accumulator_if.slave bus
);

    localparam int                 c_CNT_W   = $clog2(IN_W);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(IN_W - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic                    r_alive;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [IN_W-1:0]         r_x1;
    logic [IN_W-1:0]         r_x2;
    logic [IN_W-1:0]         r_x3;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_dout;
    logic signed [ACC_W-1:0] w_rom_sext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic                    w_in_ready;
    logic                    w_accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next_state = c_RUN;
            c_RUN:   if (r_cnt == '0) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic; r_alive keeps in_ready low until the first edge after release
    always_comb begin
        w_in_ready    = 1'b0;
        bus.rom_cs    = 1'b0;
        bus.rom_addr  = 3'b000;
        bus.out_valid = 1'b0;
        case (r_state)
            c_IDLE: w_in_ready = r_alive;
            c_RUN: begin
                bus.rom_cs   = 1'b1;
                bus.rom_addr = {r_x1[r_cnt], r_x2[r_cnt], r_x3[r_cnt]};
            end
            c_DONE:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready = w_in_ready;
    assign bus.dout     = r_dout;
    assign w_accept     = bus.in_valid && w_in_ready;

    // The sign-bit slice carries weight -2^(IN_W-1), so it enters negated.
    assign w_rom_sext = {{(ACC_W-ROM_W){bus.rom_data[ROM_W-1]}}, bus.rom_data};
    assign w_acc_next = (r_cnt == c_CNT_MAX) ? -w_rom_sext
                                             : (r_acc <<< 1) + w_rom_sext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
            r_cnt   <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_x3    <= '0;
            r_acc   <= '0;
            r_dout  <= '0;
        end else begin
            r_alive <= 1'b1;
            if (r_state == c_IDLE && w_accept) begin
                r_x1  <= bus.x1;
                r_x2  <= bus.x2;
                r_x3  <= bus.x3;
                r_acc <= '0;
                r_cnt <= c_CNT_MAX;
            end else if (r_state == c_RUN) begin
                r_acc <= w_acc_next;
                if (r_cnt == '0) begin
                    r_dout <= w_acc_next;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dct_da_accumulator.sv
// ============================================================================
// Module  : tb_dct_da_accumulator
// Brief   : Scoreboard bench for dct_da_accumulator with a behavioural DA ROM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dct_da_accumulator;

    typedef struct {
        logic signed [31:0] d;
        int                 t;
        logic [15:0]        x1;
        logic [15:0]        x2;
        logic [15:0]        x3;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   cyc;
    logic alive;
    logic signed [31:0] last_dout;
    exp_t q[$];

    dct_da_accumulator_if bus ();

    dct_da_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    function automatic logic [15:0] rom_word(input logic [2:0] a);
        case (a)
            3'b001:  return 16'h2D41;
            3'b010:  return 16'hD2BE;
            3'b100:  return 16'hD2BE;
            3'b110:  return 16'hA57D;
            3'b111:  return 16'hD2BE;
            default: return 16'h0000;
        endcase
    endfunction

    assign bus.rom_data = bus.rom_cs ? rom_word(bus.rom_addr) : 16'sh0000;

    task automatic chk(input string name, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit   busy   = 1'b0;
            automatic bit   exp_cs = 1'b0;
            automatic int   b;
            automatic logic [2:0] ea;
            if (q.size() > 0) begin
                busy   = (cyc >= q[0].t) && (cyc <= q[0].t + 16);
                exp_cs = (cyc >= q[0].t) && (cyc <= q[0].t + 15);
            end
            chk("in_ready", bus.in_ready, alive && !busy);
            chk("rom_cs", bus.rom_cs, exp_cs);
            if (exp_cs) begin
                b  = 15 - (cyc - q[0].t);
                ea = {q[0].x1[b], q[0].x2[b], q[0].x3[b]};
                chk("rom_addr", bus.rom_addr, ea);
            end else begin
                chk("rom_addr_idle", bus.rom_addr, 0);
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out_valid: got dout %0d, expected no output", bus.dout);
                end else begin
                    chk("out_time", cyc, q[0].t + 16);
                    chk("dout", bus.dout, q[0].d);
                    last_dout = q[0].d;
                    void'(q.pop_front());
                end
            end else begin
                chk("dout_hold", bus.dout, last_dout);
                if (q.size() > 0 && cyc > q[0].t + 16) begin
                    tests++;
                    fails++;
                    $display("FAIL out_timeout: got no out_valid, expected at cyc %0d", q[0].t + 16);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic signed [31:0] d, input bit hold, output int t);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x1 = a;
        bus.x2 = b;
        bus.x3 = c;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready 0, expected 1 within 100 cycles");
            bus.in_valid = 1'b0;
            t = -1;
            return;
        end
        t    = cyc + 1;
        e.d  = d;
        e.t  = t;
        e.x1 = a;
        e.x2 = b;
        e.x3 = c;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.in_valid = 1'b0;
            bus.x1 = 16'hAAAA;
            bus.x2 = 16'h5555;
            bus.x3 = 16'hFFFF;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  bus.in_ready, 0);
        chk({tag, "_rom_cs"},    bus.rom_cs, 0);
        chk({tag, "_rom_addr"},  bus.rom_addr, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_dout"},      bus.dout, 0);
    endtask

    initial begin
        int t;
        int t1;
        int t2;
        int n;
        tests        = 0;
        fails        = 0;
        cyc          = 0;
        last_dout    = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.x1       = '0;
        bus.x2       = '0;
        bus.x3       = '0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", bus.in_ready, 0);

        send(16'h0000, 16'h0000, 16'h0001,  32'sd11585,      1'b0, t); wait_idle();
        send(16'h0000, 16'h0000, 16'hFFFF, -32'sd11585,      1'b0, t); wait_idle();
        send(16'h0001, 16'h0001, 16'h0000, -32'sd23171,      1'b0, t); wait_idle();
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, -32'sd379638462,  1'b0, t); wait_idle();
        send(16'h8000, 16'h0000, 16'h0000,  32'sd379650048,  1'b0, t); wait_idle();
        send(16'h0000, 16'h0000, 16'h8000, -32'sd379617280,  1'b0, t); wait_idle();
        send(16'h0000, 16'h0001, 16'h0000, -32'sd11586,      1'b0, t); wait_idle();

        // Back-to-back with in_valid held high
        send(16'h0000, 16'h0000, 16'h0001,  32'sd11585,      1'b1, t1);
        send(16'h0001, 16'h0001, 16'h0000, -32'sd23171,      1'b0, t2);
        chk("b2b_period", t2 - t1, 18);
        wait_idle();
        repeat (4) @(negedge clk);

        // Abort mid-run at cnt=7
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, -32'sd379638462,  1'b0, t);
        n = 0;
        while (cyc != t + 8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        q.delete();
        last_dout = 0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        chk_reset_outputs("abort_hold");
        rst_n = 1'b1;
        #1;
        chk("abort_release_in_ready", bus.in_ready, 0);

        send(16'h0000, 16'h0000, 16'h0001,  32'sd11585,      1'b0, t); wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
